// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake of the DMem arbiter; one instance per requester (core, debug/DMA).
// The requester uses the master modport, the arbiter the slave modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic                  req;
  logic [DATA_W/8-1:0]   we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the four byte-lane DMem banks between the core (C) and debug/DMA (D).
// Optional feature macro DMEM_ARB_LOCK_EN adds d_lock, letting D keep the banks while it is the last winner.
module dmem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       c_bus,
  dmem_arbiter_if.slave       d_bus,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                d_lock,
`endif
  output logic [DATA_W/8-1:0] mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state, state_nxt;
  logic                last_d, owner_d, op_read;
  logic                lock_hold, c_ok, d_ok, any_req, pick_d, grant;
  logic [DATA_W/8-1:0] sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Arbitration is evaluated every cycle; ISSUE simply ignores it, so a req still high during gnt is not a new request.
  always_comb begin
    lock_hold = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    lock_hold = d_lock && last_d;
`endif
    c_ok      = c_bus.req && !lock_hold;
    d_ok      = d_bus.req;
    any_req   = c_ok || d_ok;
    pick_d    = (c_ok && d_ok) ? !last_d : d_ok;
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = any_req ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    grant     = (state != ISSUE) && any_req;
    sel_we    = pick_d ? d_bus.we    : c_bus.we;
    sel_addr  = pick_d ? d_bus.addr  : c_bus.addr;
    sel_wdata = pick_d ? d_bus.wdata : c_bus.wdata;
  end

  // Read data is captured in WAIT, in the same cycle the next access may already be granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr       <= '0;
      mem_addr     <= '0;
      mem_din      <= '0;
      c_bus.gnt    <= 1'b0;
      d_bus.gnt    <= 1'b0;
      c_bus.rvalid <= 1'b0;
      d_bus.rvalid <= 1'b0;
      c_bus.rdata  <= '0;
      d_bus.rdata  <= '0;
      last_d       <= 1'b1;
      owner_d      <= 1'b0;
      op_read      <= 1'b0;
    end else begin
      mem_wr       <= '0;
      c_bus.gnt    <= 1'b0;
      d_bus.gnt    <= 1'b0;
      c_bus.rvalid <= 1'b0;
      d_bus.rvalid <= 1'b0;
      if (state == WAIT && op_read) begin
        if (owner_d) begin
          d_bus.rdata  <= mem_dout;
          d_bus.rvalid <= 1'b1;
        end else begin
          c_bus.rdata  <= mem_dout;
          c_bus.rvalid <= 1'b1;
        end
      end
      if (grant) begin
        mem_wr    <= sel_we;
        mem_addr  <= sel_addr;
        mem_din   <= sel_wdata;
        owner_d   <= pick_d;
        op_read   <= (sel_we == '0);
        last_d    <= pick_d;
        c_bus.gnt <= !pick_d;
        d_bus.gnt <= pick_d;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level model of arbitration, timing and memory contents.
// Build with DMEM_ARB_LOCK_EN defined to also exercise d_lock.
module tb_dmem_arbiter;

  typedef struct packed {
    logic [3:0]  we;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mem_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        busy;
`ifdef DMEM_ARB_LOCK_EN
  logic        d_lock = 1'b0;
`endif

  dmem_arbiter_if c_bus ();
  dmem_arbiter_if d_bus ();

  dmem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .c_bus    (c_bus),
    .d_bus    (d_bus),
`ifdef DMEM_ARB_LOCK_EN
    .d_lock   (d_lock),
`endif
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 3) return 32'h11223344;
    return 32'h5A3C0000 ^ (i * 32'h01030507);
  endfunction

  // Four byte-lane banks with a registered read port, reloaded while rst is high.
  logic [31:0] bank [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) bank[i] <= init_word(i);
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_wr[i]) bank[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
    end
    mem_dout <= bank[mem_addr];
  end

  int          tests = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_dec = -100;
  logic        m_last_d = 1'b1;
  logic        pend_valid = 1'b0;
  logic        pend_d = 1'b0;
  int          pend_due = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] c_rdata_exp = '0;
  logic [31:0] d_rdata_exp = '0;
  logic [31:0] gold [64];
  op_t         cq[$];
  op_t         dq[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic applyStimulus();
    c_bus.req = (cq.size() > 0);
    d_bus.req = (dq.size() > 0);
    if (cq.size() > 0) begin
      c_bus.we = cq[0].we; c_bus.addr = cq[0].addr; c_bus.wdata = cq[0].wdata;
    end
    if (dq.size() > 0) begin
      d_bus.we = dq[0].we; d_bus.addr = dq[0].addr; d_bus.wdata = dq[0].wdata;
    end
  endtask

  task automatic resetModel();
    last_dec    = cyc - 100;
    m_last_d    = 1'b1;
    pend_valid  = 1'b0;
    c_rdata_exp = '0;
    d_rdata_exp = '0;
    for (int i = 0; i < 64; i++) gold[i] = init_word(i);
  endtask

  // One access per decision; decisions at least two edges apart; read data appears two edges after the grant.
  task automatic runCycle();
    logic lock_hold, c_ok, d_ok, dec, win_d, busy_exp, c_rv_exp, d_rv_exp;
    logic [3:0] wr_exp;
    op_t op;
    @(posedge clk);
    #1;
    cyc++;
    lock_hold = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    lock_hold = d_lock && m_last_d;
`endif
    c_ok     = c_bus.req && !lock_hold;
    d_ok     = d_bus.req;
    busy_exp = (cyc == last_dec + 1);
    c_rv_exp = 1'b0;
    d_rv_exp = 1'b0;
    if (pend_valid && pend_due == cyc) begin
      pend_valid = 1'b0;
      if (pend_d) begin d_rv_exp = 1'b1; d_rdata_exp = pend_data; end
      else        begin c_rv_exp = 1'b1; c_rdata_exp = pend_data; end
    end
    dec    = (cyc >= last_dec + 2) && (c_ok || d_ok);
    win_d  = (c_ok && d_ok) ? !m_last_d : d_ok;
    wr_exp = '0;
    op     = '0;
    if (dec) begin
      busy_exp = 1'b1;
      op       = win_d ? dq.pop_front() : cq.pop_front();
      wr_exp   = op.we;
      m_last_d = win_d;
      last_dec = cyc;
      if (op.we == 4'b0000) begin
        pend_valid = 1'b1; pend_due = cyc + 2; pend_d = win_d; pend_data = gold[op.addr];
      end else begin
        for (int i = 0; i < 4; i++)
          if (op.we[i]) gold[op.addr][8*i +: 8] = op.wdata[8*i +: 8];
      end
    end
    checkOutput("c_gnt", c_bus.gnt, dec && !win_d);
    checkOutput("d_gnt", d_bus.gnt, dec && win_d);
    checkOutput("c_rvalid", c_bus.rvalid, c_rv_exp);
    checkOutput("d_rvalid", d_bus.rvalid, d_rv_exp);
    checkOutput("c_rdata", c_bus.rdata, c_rdata_exp);
    checkOutput("d_rdata", d_bus.rdata, d_rdata_exp);
    checkOutput("mem_wr", mem_wr, wr_exp);
    checkOutput("busy", busy, busy_exp);
    if (dec) begin
      checkOutput("mem_addr", mem_addr, op.addr);
      checkOutput("mem_din", mem_din, op.wdata);
    end
    applyStimulus();
  endtask

  task automatic drain();
    int n = 0;
    while (n < 200 && (cq.size() > 0 || dq.size() > 0 || pend_valid || cyc <= last_dec + 2)) begin
      runCycle();
      n++;
    end
    checkOutput("drain_timeout", (n >= 200), 1'b0);
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.we    = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15));
    o.addr  = 6'($urandom_range(0, 63));
    o.wdata = $urandom;
    return o;
  endfunction

  task automatic checkReset();
    checkOutput("rst_c_gnt", c_bus.gnt, 1'b0);
    checkOutput("rst_d_gnt", d_bus.gnt, 1'b0);
    checkOutput("rst_c_rvalid", c_bus.rvalid, 1'b0);
    checkOutput("rst_d_rvalid", d_bus.rvalid, 1'b0);
    checkOutput("rst_mem_wr", mem_wr, 4'b0000);
    checkOutput("rst_mem_addr", mem_addr, 6'd0);
    checkOutput("rst_mem_din", mem_din, 32'd0);
    checkOutput("rst_c_rdata", c_bus.rdata, 32'd0);
    checkOutput("rst_d_rdata", d_bus.rdata, 32'd0);
    checkOutput("rst_busy", busy, 1'b0);
  endtask

  initial begin
    logic got;
    c_bus.req = 1'b0; c_bus.we = '0; c_bus.addr = '0; c_bus.wdata = '0;
    d_bus.req = 1'b0; d_bus.we = '0; d_bus.addr = '0; d_bus.wdata = '0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkReset();
    rst = 1'b0;

    // Directed: read of word 5, byte write into word 3, readback.
    cq.push_back('{we: 4'b0000, addr: 6'h05, wdata: 32'h0});
    cq.push_back('{we: 4'b0010, addr: 6'h03, wdata: 32'h0000AB00});
    cq.push_back('{we: 4'b0000, addr: 6'h03, wdata: 32'h0});
    applyStimulus();
    drain();

    // Tie from idle, then back-to-back core reads.
    for (int i = 0; i < 4; i++) begin
      cq.push_back('{we: 4'b0000, addr: 6'(i), wdata: 32'h0});
      dq.push_back('{we: 4'b0000, addr: 6'(i + 8), wdata: 32'h0});
    end
    applyStimulus();
    drain();
    for (int i = 0; i < 4; i++) cq.push_back('{we: 4'b0000, addr: 6'(20 + i), wdata: 32'h0});
    applyStimulus();
    drain();

    for (int n = 0; n < 600; n++) begin
      if (cq.size() < 2 && $urandom_range(0, 2) == 0) cq.push_back(rand_op());
      if (dq.size() < 2 && $urandom_range(0, 2) == 0) dq.push_back(rand_op());
      applyStimulus();
      runCycle();
    end
    drain();

`ifdef DMEM_ARB_LOCK_EN
    d_lock = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (cq.size() < 2) cq.push_back(rand_op());
      if (dq.size() < 2) dq.push_back(rand_op());
      applyStimulus();
      runCycle();
    end
    d_lock = 1'b0;
    drain();
`endif

    // Reset while a full-word core write is in ISSUE.
    cq.push_back('{we: 4'hF, addr: 6'd9, wdata: 32'hCAFEF00D});
    applyStimulus();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      runCycle();
      if (last_dec == cyc && !m_last_d) got = 1'b1;
    end
    checkOutput("midrst_grant_seen", got, 1'b1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_mem_wr", mem_wr, 4'b0000);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_c_gnt", c_bus.gnt, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    resetModel();
    for (int i = 0; i < 4; i++) runCycle();

    // Core must win the first tie after reset.
    cq.push_back('{we: 4'b0000, addr: 6'd9, wdata: 32'h0});
    dq.push_back('{we: 4'b0000, addr: 6'd5, wdata: 32'h0});
    applyStimulus();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
